// File: rtl/data_bus_arbiter_if.sv
// Requester handshakes, data_bus signals and status of data_bus_arbiter.
// master = arbiter side; slave = requesters plus data_bus side.
interface data_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_exc;
    logic              ls_req;
    logic              ls_rw;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_ack;
    logic              ls_exc;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_write;
    logic [DATA_W-1:0] bus_read;
    logic              bus_exception;
    logic              busy;

    modport master (
        input  if_req, if_addr, ls_req, ls_rw, ls_addr, ls_wdata, bus_read, bus_exception,
        output if_rdata, if_ack, if_exc, ls_rdata, ls_ack, ls_exc,
               bus_rw, bus_addr, bus_write, busy
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_rw, ls_addr, ls_wdata, bus_read, bus_exception,
        input  if_rdata, if_ack, if_exc, ls_rdata, ls_ack, ls_exc,
               bus_rw, bus_addr, bus_write, busy
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter for the single data_bus, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on collisions; default is fixed LS priority.
module data_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic reset,
    data_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    typedef enum logic {OWNER_IF, OWNER_LS} owner_t;

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t            state;
    owner_t            owner;
    logic [1:0]        wait_cnt;
    owner_t            grant_sel;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            last_grant;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_sel = OWNER_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.if_req && bus.ls_req)
            grant_sel = (last_grant == OWNER_IF) ? OWNER_LS : OWNER_IF;
        else if (bus.ls_req)
            grant_sel = OWNER_LS;
`else
        if (bus.ls_req)
            grant_sel = OWNER_LS;
`endif
        grant_addr  = (grant_sel == OWNER_LS) ? bus.ls_addr : bus.if_addr;
        grant_wdata = (grant_sel == OWNER_LS) ? bus.ls_wdata : '0;
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWNER_IF;
            wait_cnt      <= '0;
            bus.if_rdata  <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_exc    <= 1'b0;
            bus.ls_rdata  <= '0;
            bus.ls_ack    <= 1'b0;
            bus.ls_exc    <= 1'b0;
            bus.bus_rw    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_write <= '0;
            bus.busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= OWNER_IF;
`endif
        end else begin
            bus.if_ack <= 1'b0;
            bus.ls_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // A req still high during its own ack cycle is the finished one, not a new one.
                    if ((bus.if_req || bus.ls_req) && !(bus.if_ack || bus.ls_ack)) begin
                        owner         <= grant_sel;
                        bus.bus_addr  <= grant_addr;
                        bus.bus_write <= grant_wdata;
                        bus.bus_rw    <= (grant_sel == OWNER_LS) && bus.ls_rw;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant    <= grant_sel;
`endif
                    end
                end
                ACCESS: begin
                    bus.bus_rw <= 1'b0;
                    wait_cnt   <= WAIT_LOAD;
                    state      <= (RD_LAT > 1) ? WAIT : RESP;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt <= 2'd1)
                        state <= RESP;
                end
                RESP: begin
                    if (owner == OWNER_IF) begin
                        bus.if_rdata <= bus.bus_read;
                        bus.if_exc   <= bus.bus_exception;
                        bus.if_ack   <= 1'b1;
                    end else begin
                        bus.ls_rdata <= bus.bus_read;
                        bus.ls_exc   <= bus.bus_exception;
                        bus.ls_ack   <= 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus randomized request
// rounds, checked against a transaction-level model of arbitration, memory and timing.
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0000_0000_8000_0000
`endif
`ifndef MEM_END
`define MEM_END 64'h0000_0000_8000_007F
`endif

module tb_data_bus_arbiter;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int RD_LAT  = 1;
    localparam int RD_LAT3 = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset3;

    data_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    data_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

    data_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    data_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT3)) dut3 (
        .clk  (clk),
        .reset(reset3),
        .bus  (bus_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fill(input logic [63:0] a);
        return a ^ 64'h5A5A_0F0F_C3C3_9696;
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return (a >= `INITIAL_PC) && (a <= `MEM_END);
    endfunction

    function automatic int widx(input logic [63:0] a);
        logic [63:0] off;
        off = (a - `INITIAL_PC) >> 3;
        return int'(off[3:0]);
    endfunction

    // data_bus stand-in: 16-word memory, writes on a clock with rw high, reads settle by negedge
    logic [63:0] mem_a [0:15];

    always @(posedge clk)
        if (bus_a.bus_rw && in_range(bus_a.bus_addr))
            mem_a[widx(bus_a.bus_addr)] <= bus_a.bus_write;

    always @(negedge clk) begin
        bus_a.bus_read      = in_range(bus_a.bus_addr) ? mem_a[widx(bus_a.bus_addr)] : fill(bus_a.bus_addr);
        bus_a.bus_exception = !in_range(bus_a.bus_addr);
        bus_b.bus_read      = fill(bus_b.bus_addr);
        bus_b.bus_exception = !in_range(bus_b.bus_addr);
    end

    // Reference model state
    logic [63:0] model_mem [0:15];
    bit          model_last_ls;
    logic [63:0] exp_if_rdata, exp_ls_rdata;
    logic        exp_if_exc, exp_ls_exc;

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return in_range(a) ? model_mem[widx(a)] : fill(a);
    endfunction

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return `MEM_END + 64'd1;
        return `INITIAL_PC + 64'(8 * $urandom_range(0, 7));
    endfunction

    task automatic new_if_payload();
        bus_a.if_addr = rand_addr();
    endtask

    task automatic new_ls_payload();
        bus_a.ls_addr  = rand_addr();
        bus_a.ls_rw    = 1'($urandom_range(0, 1));
        bus_a.ls_wdata = {$urandom, $urandom};
    endtask

    // Next owner from the pending set: LS on collision in fixed mode, the other port in round-robin.
    function automatic bit pick_ls(input bit p_if, input bit p_ls);
        if (p_if && p_ls)
            return RR ? !model_last_ls : 1'b1;
        return p_ls;
    endfunction

    // Each port issues n back-to-back transactions, holding req until its ack.
    task automatic run_txns(input int n_if, input int n_ls, input bit fixed_first);
        int          cnt_if, cnt_ls, since, budget, rw_seen, writes;
        bit          first, exp_ls;
        logic [63:0] addr, rd;
        logic        exc;
        cnt_if  = n_if;
        cnt_ls  = n_ls;
        since   = 0;
        budget  = 0;
        rw_seen = 0;
        writes  = 0;
        first   = 1'b1;
        if (!fixed_first) begin
            new_if_payload();
            new_ls_payload();
        end
        bus_a.if_req = (cnt_if > 0);
        bus_a.ls_req = (cnt_ls > 0);
        exp_ls = pick_ls(cnt_if > 0, cnt_ls > 0);
        if (cnt_if > 0 || cnt_ls > 0)
            model_last_ls = exp_ls;
        while ((cnt_if > 0 || cnt_ls > 0) && budget < 400) begin
            tick();
            since++;
            budget++;
            if (bus_a.bus_rw)
                rw_seen++;
            if (first && since == 1)
                check("access_addr", bus_a.bus_addr, exp_ls ? bus_a.ls_addr : bus_a.if_addr);
            if (bus_a.if_ack || bus_a.ls_ack) begin
                check("ack_port", {bus_a.ls_ack, bus_a.if_ack}, exp_ls ? 64'd2 : 64'd1);
                check("latency", since, first ? RD_LAT + 2 : RD_LAT + 3);
                first = 1'b0;
                since = 0;
                addr  = exp_ls ? bus_a.ls_addr : bus_a.if_addr;
                if (exp_ls && bus_a.ls_rw) begin
                    writes++;
                    if (in_range(addr))
                        model_mem[widx(addr)] = bus_a.ls_wdata;
                end
                rd  = model_rd(addr);
                exc = !in_range(addr);
                if (exp_ls) begin
                    exp_ls_rdata = rd;
                    exp_ls_exc   = exc;
                end else begin
                    exp_if_rdata = rd;
                    exp_if_exc   = exc;
                end
                check("if_rdata", bus_a.if_rdata, exp_if_rdata);
                check("if_exc", bus_a.if_exc, exp_if_exc);
                check("ls_rdata", bus_a.ls_rdata, exp_ls_rdata);
                check("ls_exc", bus_a.ls_exc, exp_ls_exc);
                check("bus_addr", bus_a.bus_addr, addr);
                if (exp_ls) begin
                    cnt_ls--;
                    if (cnt_ls > 0) new_ls_payload();
                    else bus_a.ls_req = 1'b0;
                end else begin
                    cnt_if--;
                    if (cnt_if > 0) new_if_payload();
                    else bus_a.if_req = 1'b0;
                end
                if (cnt_if > 0 || cnt_ls > 0) begin
                    exp_ls = pick_ls(cnt_if > 0, cnt_ls > 0);
                    model_last_ls = exp_ls;
                end
            end
        end
        check("pending_left", cnt_if + cnt_ls, 0);
        tick();
        check("ack_pulse", {bus_a.ls_ack, bus_a.if_ack}, 0);
        check("busy_idle", bus_a.busy, 0);
        check("bus_rw_cycles", rw_seen, writes);
    endtask

    int acks3, lat3;

    initial begin
        reset  = 1'b1;
        reset3 = 1'b1;
        bus_a.if_req = 1'b0; bus_a.if_addr = '0;
        bus_a.ls_req = 1'b0; bus_a.ls_rw = 1'b0; bus_a.ls_addr = '0; bus_a.ls_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0;
        bus_b.ls_req = 1'b0; bus_b.ls_rw = 1'b0; bus_b.ls_addr = '0; bus_b.ls_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i]     = fill(`INITIAL_PC + 64'(8 * i));
            model_mem[i] = fill(`INITIAL_PC + 64'(8 * i));
        end
        model_last_ls = 1'b0;
        exp_if_rdata = '0; exp_ls_rdata = '0;
        exp_if_exc = 1'b0; exp_ls_exc = 1'b0;

        // Reset held with both requests high: nothing may start
        bus_a.if_req = 1'b1;
        bus_a.ls_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ack", {bus_a.ls_ack, bus_a.if_ack}, 0);
            check("rst_bus_rw", bus_a.bus_rw, 0);
            check("rst_busy", bus_a.busy, 0);
        end
        check("rst_ls_rdata", bus_a.ls_rdata, 0);
        reset = 1'b0;
        run_txns(1, 1, 1'b0);

        // Fetch read at the reset PC
        bus_a.if_addr = `INITIAL_PC;
        run_txns(1, 0, 1'b1);

        // Store then load of the same word
        bus_a.ls_addr  = `INITIAL_PC + 64'd8;
        bus_a.ls_rw    = 1'b1;
        bus_a.ls_wdata = 64'hDEAD_BEEF;
        run_txns(0, 1, 1'b1);
        bus_a.ls_rw = 1'b0;
        run_txns(0, 1, 1'b1);
        check("rd_after_wr", bus_a.ls_rdata, 64'hDEAD_BEEF);

        // Both ports saturated
        run_txns(3, 3, 1'b0);

        // Out-of-range load reports an exception to LS only
        bus_a.ls_addr = `MEM_END + 64'd1;
        bus_a.ls_rw   = 1'b0;
        run_txns(0, 1, 1'b1);
        check("oob_exc", bus_a.ls_exc, 1);

        for (int r = 0; r < 30; r++)
            run_txns($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

        // Reset during WAIT on the RD_LAT=3 instance aborts without an ack
        tick();
        reset3 = 1'b0;
        bus_b.ls_addr = `INITIAL_PC + 64'd16;
        bus_b.ls_req  = 1'b1;
        tick();
        check("wait_busy", bus_b.busy, 1);
        tick();
        tick();
        reset3 = 1'b1;
        tick();
        check("abort_busy", bus_b.busy, 0);
        check("abort_ack", {bus_b.ls_ack, bus_b.if_ack}, 0);
        reset3 = 1'b0;
        bus_b.ls_req = 1'b0;
        acks3 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_b.ls_ack || bus_b.if_ack) acks3++;
        end
        check("abort_no_ack", acks3, 0);
        bus_b.ls_addr = `INITIAL_PC + 64'd24;
        bus_b.ls_req  = 1'b1;
        lat3 = 0;
        for (int i = 1; i <= 20 && lat3 == 0; i++) begin
            tick();
            if (bus_b.ls_ack) lat3 = i;
        end
        bus_b.ls_req = 1'b0;
        check("lat3", lat3, RD_LAT3 + 2);
        check("lat3_rdata", bus_b.ls_rdata, fill(`INITIAL_PC + 64'd24));
        check("lat3_exc", bus_b.ls_exc, 0);
        check("lat3_if_ack", bus_b.if_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
